// File: rtl/ef_dac1008_player.sv
// ef_dac1008_player: FIFO-fed DAC sample player.
// Samples are written into a small FIFO. After the FIFO has primed to a
// threshold, the player pops one word per sample period and presents it on
// dac_data with a one-cycle load pulse. Sticky flags record underrun and
// overflow events.
module ef_dac1008_player #(
    parameter int DW    = 10,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [7:0]    sample_div,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          flush,
    input  logic [4:0]    fifo_threshold,
    output logic [4:0]    fifo_level,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          fifo_below,
    output logic [DW-1:0] dac_data,
    output logic          load,
    output logic          underrun,
    output logic          overflow,
    input  logic          err_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [4:0]    level;
    logic [DW-1:0] mem [DEPTH];
    logic [4:0]    eff_thr;
    logic          tick;
    logic          pop;
    logic          push;
    logic          drop;

    assign fifo_level = level;
    assign fifo_full  = (level == 5'(DEPTH));
    assign fifo_empty = (level == 5'd0);
    assign fifo_below = (level < eff_thr);

    // Clamp the prime threshold so an oversized value still means "completely full".
    always_comb begin
        eff_thr = fifo_threshold;
        if (fifo_threshold > 5'(DEPTH)) begin
            eff_thr = 5'(DEPTH);
        end
    end

    // Playback sequencing: next state, tick counter and the per-cycle FIFO actions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tick      = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = PRIME;
                end
                PRIME: begin
                    if (level >= eff_thr) begin
                        state_nxt = RUN;
                        cnt_nxt   = 8'd0;
                    end
                end
                RUN: begin
                    if (cnt == 8'd0) begin
                        tick    = 1'b1;
                        cnt_nxt = sample_div;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
        // A flush cancels both the pop and the write of its cycle; a write into
        // a full FIFO survives only when the same cycle frees a slot.
        pop  = tick && !fifo_empty && !flush;
        push = wr && !flush && (!fifo_full || pop);
        drop = wr && !flush && fifo_full && !pop;
    end

    // State, pointers, output register and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            rptr     <= '0;
            wptr     <= '0;
            level    <= 5'd0;
            dac_data <= '0;
            load     <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            load  <= pop;
            if (pop) begin
                dac_data <= mem[rptr];
            end
            if (flush) begin
                rptr  <= '0;
                wptr  <= '0;
                level <= 5'd0;
            end else begin
                if (push) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   level <= level + 5'd1;
                    2'b01:   level <= level - 5'd1;
                    default: level <= level;
                endcase
            end
            underrun <= (tick && fifo_empty) || (underrun && !err_clr);
            overflow <= drop || (overflow && !err_clr);
        end
    end

    // Sample storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: tb/tb_ef_dac1008_player.sv
// Directed testbench for ef_dac1008_player.
module tb_ef_dac1008_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] sample_div = 8'd0;
    logic       wr = 1'b0;
    logic [9:0] wdata = 10'd0;
    logic       flush = 1'b0;
    logic [4:0] fifo_threshold = 5'd0;
    logic [4:0] fifo_level;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_below;
    logic [9:0] dac_data;
    logic       load;
    logic       underrun;
    logic       overflow;
    logic       err_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    int         load_step [$];
    logic [9:0] load_val  [$];

    ef_dac1008_player #(.DW(10), .DEPTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sample_div(sample_div),
        .wr(wr),
        .wdata(wdata),
        .flush(flush),
        .fifo_threshold(fifo_threshold),
        .fifo_level(fifo_level),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_below(fifo_below),
        .dac_data(dac_data),
        .load(load),
        .underrun(underrun),
        .overflow(overflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int s);
        if (load === 1'b1) begin
            load_step.push_back(s);
            load_val.push_back(dac_data);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({fifo_level, fifo_empty, fifo_full, dac_data, load, underrun, overflow} !==
            {5'd0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL reset_state: level=%0d empty=%b full=%b dac=%0d load=%b ur=%b ov=%b, required 0 1 0 0 0 0 0",
                     fifo_level, fifo_empty, fifo_full, dac_data, load, underrun, overflow);
        end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_prime_and_underrun();
        int ur_step;
        int early_loads;
        fifo_threshold = 5'd4;
        sample_div     = 8'd3;
        en             = 1'b1;
        early_loads    = 0;
        for (int k = 1; k <= 4; k++) begin
            wr    = 1'b1;
            wdata = 10'(k);
            step();
            if (load === 1'b1) early_loads++;
            if (k == 3) begin
                n_cmp++;
                if (fifo_below !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL prime_below_3: got %b, required 1", fifo_below);
                end
            end
        end
        wr = 1'b0;
        n_cmp++;
        if (fifo_below !== 1'b0 || early_loads != 0) begin
            n_err++;
            $display("[TB] FAIL prime_no_early_load: below=%b loads=%0d, required 0 0", fifo_below, early_loads);
        end
        load_step.delete();
        load_val.delete();
        ur_step = -1;
        for (int s = 0; s < 30; s++) begin
            step();
            record(s);
            if (underrun === 1'b1 && ur_step < 0) ur_step = s;
        end
        n_cmp++;
        if (load_step.size() != 4) begin
            n_err++;
            $display("[TB] FAIL prime_load_count: got %0d, required 4", load_step.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (load_val[i] !== 10'(i + 1) || load_step[i] != 1 + 4 * i) begin
                    n_err++;
                    $display("[TB] FAIL prime_load_%0d: got value %0d at step %0d, required %0d at step %0d",
                             i, load_val[i], load_step[i], i + 1, 1 + 4 * i);
                end
            end
            n_cmp++;
            if (ur_step != load_step[3] + 4) begin
                n_err++;
                $display("[TB] FAIL underrun_timing: got step %0d, required %0d", ur_step, load_step[3] + 4);
            end
        end
        n_cmp++;
        if (dac_data !== 10'd4) begin
            n_err++;
            $display("[TB] FAIL underrun_hold: dac=%0d, required 4", dac_data);
        end
        en = 1'b0;
        step();
        step();
        n_cmp++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL underrun_sticky: got %b, required 1", underrun);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_cmp++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL underrun_clear: got %b, required 0", underrun);
        end
    endtask

    task automatic test_overflow();
        fifo_threshold = 5'd31;
        for (int k = 0; k < 17; k++) begin
            wr    = 1'b1;
            wdata = 10'(100 + k);
            step();
            if (k == 14) begin
                n_cmp++;
                if (fifo_level !== 5'd15 || fifo_below !== 1'b1 || fifo_full !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL level_15: level=%0d below=%b full=%b, required 15 1 0",
                             fifo_level, fifo_below, fifo_full);
                end
            end
        end
        wr = 1'b0;
        n_cmp++;
        if (fifo_level !== 5'd16 || fifo_full !== 1'b1 || overflow !== 1'b1 || fifo_below !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL overflow_state: level=%0d full=%b ov=%b below=%b, required 16 1 1 0",
                     fifo_level, fifo_full, overflow, fifo_below);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0 || fifo_level !== 5'd16) begin
            n_err++;
            $display("[TB] FAIL overflow_clear: ov=%b level=%0d, required 0 16", overflow, fifo_level);
        end
    endtask

    task automatic test_full_plus_pop();
        int bad;
        logic [9:0] exp_v;
        sample_div     = 8'd0;
        fifo_threshold = 5'd16;
        en             = 1'b1;
        step();
        step();
        load_step.delete();
        load_val.delete();
        bad = 0;
        for (int s = 0; s < 8; s++) begin
            wr    = 1'b1;
            wdata = 10'(200 + s);
            step();
            record(s);
            if (fifo_level !== 5'd16 || overflow !== 1'b0) bad++;
        end
        wr = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("[TB] FAIL full_pop_level: %0d cycles off, required level 16 overflow 0 throughout", bad);
        end
        for (int s = 8; s < 28; s++) begin
            step();
            record(s);
        end
        n_cmp++;
        if (load_step.size() != 24) begin
            n_err++;
            $display("[TB] FAIL full_pop_count: got %0d loads, required 24", load_step.size());
        end else begin
            for (int i = 0; i < 24; i++) begin
                exp_v = (i < 16) ? 10'(100 + i) : 10'(200 + i - 16);
                n_cmp++;
                if (load_val[i] !== exp_v || load_step[i] != i) begin
                    n_err++;
                    $display("[TB] FAIL full_pop_seq_%0d: got %0d at step %0d, required %0d at step %0d",
                             i, load_val[i], load_step[i], exp_v, i);
                end
            end
        end
        en = 1'b0;
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            wr    = 1'b1;
            wdata = 10'(400 + k);
            step();
        end
        flush = 1'b1;
        wdata = 10'd403;
        step();
        flush = 1'b0;
        wr    = 1'b0;
        n_cmp++;
        if (fifo_level !== 5'd0 || fifo_empty !== 1'b1 || overflow !== 1'b0 || load !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL flush_wr: level=%0d empty=%b ov=%b load=%b, required 0 1 0 0",
                     fifo_level, fifo_empty, overflow, load);
        end
        for (int k = 0; k < 16; k++) begin
            wr    = 1'b1;
            wdata = 10'(450 + k);
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        wr    = 1'b0;
        n_cmp++;
        if (fifo_level !== 5'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL flush_full_wr: level=%0d ov=%b, required 0 0", fifo_level, overflow);
        end
        fifo_threshold = 5'd2;
        sample_div     = 8'd1;
        en             = 1'b1;
        wr             = 1'b1;
        wdata          = 10'd300;
        step();
        wr = 1'b0;
        load_step.delete();
        load_val.delete();
        for (int s = 0; s < 6; s++) begin
            step();
            record(s);
        end
        n_cmp++;
        if (load_step.size() != 0) begin
            n_err++;
            $display("[TB] FAIL reprime_hold: got %0d loads, required 0", load_step.size());
        end
        wr    = 1'b1;
        wdata = 10'd301;
        step();
        wr = 1'b0;
        for (int s = 0; s < 12; s++) begin
            step();
            record(s);
        end
        n_cmp++;
        if (load_step.size() != 2) begin
            n_err++;
            $display("[TB] FAIL reprime_count: got %0d loads, required 2", load_step.size());
        end else begin
            n_cmp++;
            if (load_val[0] !== 10'd300 || load_val[1] !== 10'd301) begin
                n_err++;
                $display("[TB] FAIL reprime_values: got %0d %0d, required 300 301", load_val[0], load_val[1]);
            end
        end
        en = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 17; k++) begin
            wr    = 1'b1;
            wdata = 10'(600 + k);
            step();
        end
        wr             = 1'b0;
        fifo_threshold = 5'd0;
        sample_div     = 8'd2;
        en             = 1'b1;
        for (int s = 0; s < 7; s++) step();
        n_cmp++;
        if (dac_data === 10'd0 || overflow !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL pre_reset_run: dac=%0d ov=%b, required nonzero 1", dac_data, overflow);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({fifo_level, fifo_empty, fifo_full, dac_data, load, underrun, overflow} !==
            {5'd0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL async_reset: level=%0d empty=%b full=%b dac=%0d load=%b ur=%b ov=%b, required 0 1 0 0 0 0 0",
                     fifo_level, fifo_empty, fifo_full, dac_data, load, underrun, overflow);
        end
        step();
        rst = 1'b0;
        step();
        step();
        wr    = 1'b1;
        wdata = 10'd500;
        step();
        wr = 1'b0;
        load_step.delete();
        load_val.delete();
        for (int s = 0; s < 10; s++) begin
            step();
            record(s);
        end
        n_cmp++;
        if (load_step.size() != 1) begin
            n_err++;
            $display("[TB] FAIL post_reset_count: got %0d loads, required 1", load_step.size());
        end else begin
            n_cmp++;
            if (load_val[0] !== 10'd500) begin
                n_err++;
                $display("[TB] FAIL post_reset_value: got %0d, required 500", load_val[0]);
            end
        end
        en = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_prime_and_underrun();
        test_overflow();
        test_full_plus_pop();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
